// File: rtl/imem_sync_loadable_if.sv
// Fetch/load bus between the IF stage, the boot loader and the instruction memory.
// The master drives addresses and load data; the slave (memory) returns the registered fetch.
interface imem_sync_loadable_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WORDS_LOG2 = 8
);
  logic [31:0]                fetch_addr;
  logic                       fetch_en;
  logic                       stall;
  logic                       flush;
  logic                       load_we;
  logic [ADDR_WORDS_LOG2-1:0] load_addr;
  logic [DATA_WIDTH-1:0]      load_data;
  logic [DATA_WIDTH-1:0]      instr;
  logic                       instr_valid;
  logic                       addr_err;
  logic                       ready;

  modport master (
    output fetch_addr, fetch_en, stall, flush, load_we, load_addr, load_data,
    input  instr, instr_valid, addr_err, ready
  );

  modport slave (
    input  fetch_addr, fetch_en, stall, flush, load_we, load_addr, load_data,
    output instr, instr_valid, addr_err, ready
  );
endinterface

// File: rtl/imem_sync_loadable.sv
// Synchronous-read instruction memory with one-cycle fetch latency, stall/flush-aware output
// register, runtime program-load port and an optional post-reset clear sequencer.
module imem_sync_loadable #(
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          ADDR_WORDS_LOG2 = 8,
  parameter bit                   CLEAR_ON_RESET  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = '0
) (
  input logic                  i_clk,
  input logic                  i_reset,
  imem_sync_loadable_if.slave  io_bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WORDS_LOG2;
  localparam int unsigned CNT_W = ADDR_WORDS_LOG2 + 1;

  typedef enum logic {StClear, StRun} state_e;

  state_e                     r_state, w_state_next;
  logic [CNT_W-1:0]           r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]      r_instr;
  logic                       r_valid;
  logic                       r_err;

  logic                       w_we;
  logic [ADDR_WORDS_LOG2-1:0] w_waddr;
  logic [DATA_WIDTH-1:0]      w_wdata;
  logic [ADDR_WORDS_LOG2-1:0] w_index;
  logic                       w_oor;
  logic                       w_mis;
  logic                       w_legal;
  logic                       w_clear_done;

  assign w_index      = io_bus.fetch_addr[ADDR_WORDS_LOG2+1:2];
  assign w_oor        = (io_bus.fetch_addr >> (ADDR_WORDS_LOG2 + 2)) != '0;
  assign w_mis        = io_bus.fetch_addr[1:0] != 2'b00;
  assign w_legal      = !w_oor && !w_mis;
  // Explicit terminal compare; the counter has a spare bit and never relies on wrapping.
  assign w_clear_done = r_cnt == CNT_W'(DEPTH - 1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_we         = 1'b0;
    w_waddr      = io_bus.load_addr;
    w_wdata      = io_bus.load_data;
    unique case (r_state)
      StClear: begin
        w_we       = 1'b1;
        w_waddr    = r_cnt[ADDR_WORDS_LOG2-1:0];
        w_wdata    = '0;
        w_cnt_next = r_cnt + CNT_W'(1);
        if (w_clear_done) w_state_next = StRun;
      end
      StRun: w_we = io_bus.load_we;
    endcase
    if (i_reset) w_we = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= CLEAR_ON_RESET ? StClear : StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Contents are deliberately not reset so a CLEAR_ON_RESET=0 build keeps its program.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Reads the array before the same-edge write lands, giving read-first behaviour.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == StRun) begin
      if (io_bus.flush) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end else if (io_bus.stall) begin
        r_instr <= r_instr;
        r_valid <= r_valid;
        r_err   <= r_err;
      end else if (io_bus.fetch_en && w_legal) begin
        r_instr <= r_mem[w_index];
        r_valid <= 1'b1;
        r_err   <= 1'b0;
      end else if (io_bus.fetch_en) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  assign io_bus.instr       = r_instr;
  assign io_bus.instr_valid = r_valid;
  assign io_bus.addr_err    = r_err;
  assign io_bus.ready       = (r_state == StRun) && !i_reset;

endmodule

// File: doc/imem_sync_loadable.md
Name: imem_sync_loadable

Overview:
- Parametrised successor to the combinational instruction ROM for the pipelined MIPS core.
- A synchronous-read instruction memory with a one-cycle fetch latency and a stall/flush-aware output register.
- Has a runtime program-load write port (driven by the UART boot loader) and an optional post-reset clear sequencer.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- ADDR_WORDS_LOG2, 8, log2 of word depth; DEPTH = 2**ADDR_WORDS_LOG2 words.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset via the sequencer; 0 = contents survive reset.
- NOP_WORD, 32'h00000000, word emitted on flush, out-of-range or misaligned fetch (sll $0,$0,0).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_addr  in  32  byte address from the PC.
- fetch_en  in  1  request a fetch this cycle.
- stall  in  1  hold the output register (IF/ID stall).
- flush  in  1  replace the output with NOP_WORD (branch/jump taken).
- load_we  in  1  program-load write strobe.
- load_addr  in  ADDR_WORDS_LOG2  word index for the load write.
- load_data  in  DATA_WIDTH  load write data.
- instr  out  DATA_WIDTH  registered instruction.
- instr_valid  out  1  instr holds a real fetched word.
- addr_err  out  1  registered flag: last fetch misaligned or out of range.
- ready  out  1  memory accepts fetches and loads.

Behaviour:
- Storage is an array of DEPTH x DATA_WIDTH words. Word index = fetch_addr[ADDR_WORDS_LOG2+1:2].
- Out of range: any fetch_addr bit above ADDR_WORDS_LOG2+1 is set.
- Misaligned: fetch_addr[1:0] != 0.

FSM states: CLEAR, RUN.
- reset=1 gives the following values on the next edge:
  - instr=NOP_WORD, instr_valid=0, addr_err=0.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET else RUN.
  - ready=0 throughout reset.
- CLEAR:
  - Each cycle writes 0 to word[counter] and increments the counter.
  - After writing word DEPTH-1, moves to RUN on the next edge.
  - Duration is exactly DEPTH cycles after reset deasserts; ready=0 the whole time.
  - fetch_en and load_we are ignored; outputs hold their reset values.
- RUN:
  - ready=1.
  - load_we writes load_data to word[load_addr] at the clock edge.

Output register update in RUN, in priority order at each edge:
1. flush=1: instr=NOP_WORD, instr_valid=0, addr_err=0. Flush overrides stall.
2. stall=1: instr, instr_valid and addr_err hold.
3. fetch_en=1, address legal: instr=word[index], instr_valid=1, addr_err=0.
4. fetch_en=1, address illegal: instr=NOP_WORD, instr_valid=0, addr_err=1.
5. fetch_en=0: instr=NOP_WORD, instr_valid=0, addr_err=0.

Timing and boundaries:
- Latency: address presented at edge N gives its data visible after edge N+1 (one cycle). No combinational path from fetch_addr to instr.
- Read-during-write to the same word in the same cycle is read-first: the fetch returns the old word, and the new word is visible from the next fetch.
- A load during stall is still performed; the held instr does not change.
- Reset mid-CLEAR restarts the sequencer at word 0.
- Reset in RUN with CLEAR_ON_RESET=0 keeps memory contents and clears only the output registers.
- Clear-counter wrap: the counter is ADDR_WORDS_LOG2+1 bits wide; termination on counter==DEPTH-1 is written explicitly, with no reliance on overflow.
- Highest legal fetch_addr = 4*(DEPTH-1), which is 0x3FC for the default depth.

Test Plan:
- Clear sequencer, CLEAR_ON_RESET=1, DEPTH=256: pulse reset 1 cycle -> ready=0 for exactly 256 cycles, then 1; a fetch of 0x3FC then returns 0 with instr_valid=1.
- Load then fetch: load word 0 = 0x20040003 and word 1 = 0x0C000003; fetch 0x0 then 0x4 on consecutive cycles -> instr shows 0x20040003 then 0x0C000003, each one cycle after its address, instr_valid=1.
- Stall/flush priority: while instr=0x0C000003, assert stall 3 cycles with a changing fetch_addr -> instr held. Assert stall and flush together -> instr=0x00000000, instr_valid=0.
- Address errors: fetch 0x402 -> addr_err=1, instr=NOP_WORD. Fetch 0x400 -> addr_err=1. Fetch 0x3FC -> addr_err=0.
- Read-during-write: word 5 holds 0x11111111; in the same cycle load word 5 = 0x22222222 and fetch 0x14 -> 0x11111111; the next fetch of 0x14 -> 0x22222222.
- Reset retention, CLEAR_ON_RESET=0: load word 3 = 0xDEADBEEF, reset 2 cycles -> ready=1 immediately after reset; a fetch of 0xC returns 0xDEADBEEF.
